// File: rtl/rv_wb_arbiter_if.sv
// rv_wb_arbiter_if: two-master Wishbone bundle between the masters, the arbiter and the slave
interface rv_wb_arbiter_if;
  logic [1:0]  i_m_cyc;
  logic [1:0]  i_m_stb;
  logic [1:0]  i_m_we;
  logic [7:0]  i_m_sel;
  logic [63:0] i_m_adr;
  logic [63:0] i_m_dat;
  logic [1:0]  o_m_ack;
  logic [1:0]  o_m_err;
  logic [31:0] o_m_dat;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic        o_wb_stb;
  logic        o_wb_cyc;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic [1:0]  o_grant;
  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_sel, i_m_adr, i_m_dat, i_wb_dat, i_wb_ack,
    output o_m_ack, o_m_err, o_m_dat, o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc, o_grant
  );
  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_sel, i_m_adr, i_m_dat, i_wb_dat, i_wb_ack,
    input  o_m_ack, o_m_err, o_m_dat, o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc, o_grant
  );
endinterface

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: two-master round-robin Wishbone arbiter with an ack timeout
module rv_wb_arbiter #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input logic            i_clk,
  input logic            i_reset_n,
  rv_wb_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = (TIMEOUT == 0) ? {CNT_WIDTH{1'b1}} : CNT_WIDTH'(TIMEOUT - 1);
  state_t state, state_nx;
  logic owner, owner_nx, last, last_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic busy, own_cyc, own_stb, run, tmo;
  logic [1:0] own_hot;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end
  always_comb begin
    busy     = state == BUSY;
    own_cyc  = bus.i_m_cyc[owner];
    own_stb  = bus.i_m_stb[owner];
    own_hot  = owner ? 2'b10 : 2'b01;
    run      = busy && own_cyc && own_stb && !bus.i_wb_ack;
    // ack on the last allowed cycle beats the timeout
    tmo      = TIMEOUT != 0 && run && cnt == CNT_MAX;
    cnt_nx   = !run ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    if (state == IDLE && |bus.i_m_cyc) begin
      state_nx = BUSY;
      owner_nx = &bus.i_m_cyc ? ~last : bus.i_m_cyc[1];
    end else if (busy && !own_cyc) begin
      state_nx = IDLE;
      last_nx  = owner;
    end else if (tmo) begin
      state_nx = ERR;
    end else if (state == ERR) begin
      state_nx = IDLE;
      last_nx  = owner;
    end
    bus.o_wb_cyc = busy && own_cyc;
    bus.o_wb_stb = busy && own_stb;
    bus.o_wb_we  = busy && bus.i_m_we[owner];
    bus.o_wb_sel = busy ? bus.i_m_sel[{owner, 2'b00} +: 4] : 4'h0;
    bus.o_wb_adr = busy ? bus.i_m_adr[{owner, 5'd0} +: 32] : 32'h0;
    bus.o_wb_dat = busy ? bus.i_m_dat[{owner, 5'd0} +: 32] : 32'h0;
    bus.o_m_ack  = (busy && bus.i_wb_ack) ? own_hot : 2'b00;
    bus.o_m_err  = (state == ERR) ? own_hot : 2'b00;
    bus.o_grant  = busy ? own_hot : 2'b00;
    bus.o_m_dat  = bus.i_wb_dat;
  end
endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb_rv_wb_arbiter: randomized two-master traffic checked by a response scoreboard and arbitration rules
module tb_rv_wb_arbiter;
  localparam int TO = 4;
  typedef struct packed {logic cyc, stb, we; logic [3:0] sel; logic [31:0] adr, dat;} drv_t;
  typedef struct {logic we; logic [3:0] sel; logic [31:0] adr, dat; bit err;} exp_t;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int checks = 0;
  int passes = 0;
  drv_t drv [2];
  exp_t exp_q [2][$];
  logic [2:0] scnt;
  rv_wb_arbiter_if bus();
  rv_wb_arbiter #(.TIMEOUT(TO), .CNT_WIDTH(8)) dut (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus));
  always #5 i_clk = ~i_clk;
  assign bus.i_m_cyc = {drv[1].cyc, drv[0].cyc};
  assign bus.i_m_stb = {drv[1].stb, drv[0].stb};
  assign bus.i_m_we  = {drv[1].we, drv[0].we};
  assign bus.i_m_sel = {drv[1].sel, drv[0].sel};
  assign bus.i_m_adr = {drv[1].adr, drv[0].adr};
  assign bus.i_m_dat = {drv[1].dat, drv[0].dat};
  // slave acks after adr[6:4] strobed wait cycles, so each beat carries its own latency
  always @(posedge i_clk) scnt <= (bus.o_wb_stb && !bus.i_wb_ack) ? scnt + 3'd1 : 3'd0;
  assign bus.i_wb_ack = bus.o_wb_stb && scnt == bus.o_wb_adr[6:4];
  always @(posedge i_clk) bus.i_wb_dat <= $urandom;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic run(input int m, input int nb, input int maxdly, input logic [31:0] a0);
    exp_t e;
    logic [31:0] a;
    int n;
    for (int b = 0; b < nb; b++) begin
      a = $urandom;
      a[6:4] = 3'($urandom_range(maxdly, 0));
      if (b == 0 && a0 != 0) a = a0;
      e.we = 1'($urandom);
      e.sel = 4'($urandom);
      e.dat = $urandom;
      e.adr = a;
      e.err = int'(a[6:4]) + 1 > TO;
      exp_q[m].push_back(e);
      drv[m].cyc = 1'b1;
      drv[m].stb = 1'b1;
      drv[m].we = e.we;
      drv[m].sel = e.sel;
      drv[m].adr = e.adr;
      drv[m].dat = e.dat;
      n = 0;
      do begin @(negedge i_clk); n++; end while (!bus.o_m_ack[m] && !bus.o_m_err[m] && n < 300);
      check("resp_arrives", 128'(n < 300), 128'(1));
      @(posedge i_clk); #1;
      drv[m].stb = 1'b0;
      if (e.err || b == nb - 1) begin
        drv[m].cyc = 1'b0;
        break;
      end
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [1:0] p_grant, p_err, p_cyc, g;
    bit m_last;
    int scyc [2];
    exp_t e;
    p_grant = 0; p_err = 0; p_cyc = 0; m_last = 1; scyc[0] = 0; scyc[1] = 0;
    forever begin
      @(negedge i_clk);
      if (!i_reset_n) begin
        check("reset_outs", 128'({bus.o_m_ack, bus.o_m_err, bus.o_grant, bus.o_wb_cyc, bus.o_wb_stb,
              bus.o_wb_we, bus.o_wb_sel, bus.o_wb_adr, bus.o_wb_dat}), 128'(0));
        p_grant = 0; p_err = 0; p_cyc = 0; m_last = 1; scyc[0] = 0; scyc[1] = 0;
      end else begin
        if (p_grant == 2'b00) begin
          if (p_err == 2'b00 && p_cyc != 2'b00) begin
            g = (p_cyc == 2'b11) ? (m_last ? 2'b01 : 2'b10) : p_cyc;
            check("grant_arb", 128'(bus.o_grant), 128'(g));
            m_last = g[1];
          end else check("grant_idle", 128'(bus.o_grant), 128'(0));
        end else if (!p_cyc[p_grant[1]]) check("grant_release", 128'({bus.o_grant, bus.o_m_err}), 128'(0));
        else if (bus.o_m_err == 2'b00) check("grant_hold", 128'(bus.o_grant), 128'(p_grant));
        for (int m = 0; m < 2; m++) begin
          if (bus.o_m_ack[m] || bus.o_m_err[m]) begin
            check("resp_expected", 128'(exp_q[m].size() != 0), 128'(1));
            if (exp_q[m].size() != 0) begin
              e = exp_q[m].pop_front();
              check("resp_kind", 128'(bus.o_m_err[m]), 128'(e.err));
              if (bus.o_m_ack[m]) begin
                check("ack_beat", 128'({bus.o_wb_we, bus.o_wb_sel, bus.o_wb_adr, bus.o_wb_dat, bus.o_wb_cyc, bus.o_grant}),
                      128'({e.we, e.sel, e.adr, e.dat, 1'b1, (m == 0) ? 2'b01 : 2'b10}));
                check("ack_latency", 128'(scyc[m]), 128'(e.adr[6:4]));
                check("rdata", 128'(bus.o_m_dat), 128'(bus.i_wb_dat));
              end else begin
                check("err_latency", 128'(scyc[m]), 128'(TO));
                check("err_bus_idle", 128'({bus.o_wb_cyc, bus.o_wb_stb, bus.o_grant}), 128'(0));
              end
            end
          end
          scyc[m] = (bus.o_grant[m] && bus.o_wb_stb && !bus.o_m_ack[m]) ? scyc[m] + 1 : 0;
        end
        p_grant = bus.o_grant; p_err = bus.o_m_err; p_cyc = bus.i_m_cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks expected completion", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv[0] = '0;
    drv[1] = '0;
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    fork
      repeat (4) run(0, 1, 3, 0);
      repeat (4) run(1, 1, 3, 0);
    join
    fork
      run(0, 1, 0, 32'h2000_0010);
      begin
        @(negedge i_clk); check("req_no_grant_yet", 128'(bus.o_grant), 128'(0));
        @(negedge i_clk); check("req_grant_m0", 128'(bus.o_grant), 128'(2'b01));
        check("req_adr", 128'(bus.o_wb_adr), 128'(32'h2000_0010));
      end
    join
    fork
      run(1, 3, 2, 0);
      begin @(posedge i_clk); #1; run(0, 1, 2, 0); end
    join
    run(0, 1, 0, 32'h1000_0070);
    run(1, 1, 0, 32'h1000_0030);
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(2, 0)) begin @(posedge i_clk); #1; end
        run(0, $urandom_range(3, 1), 5, 0);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(2, 0)) begin @(posedge i_clk); #1; end
        run(1, $urandom_range(3, 1), 5, 0);
      end
    join
    drv[0].cyc = 1'b1; drv[0].stb = 1'b1; drv[0].we = 1'b1; drv[0].sel = 4'hf;
    drv[0].adr = 32'h0000_0070; drv[0].dat = 32'hdead_beef;
    repeat (3) @(negedge i_clk);
    check("pre_reset_grant", 128'(bus.o_grant), 128'(2'b01));
    #2 i_reset_n = 1'b0;
    #1 check("async_reset", 128'({bus.o_m_ack, bus.o_m_err, bus.o_grant, bus.o_wb_cyc, bus.o_wb_stb,
             bus.o_wb_we, bus.o_wb_sel, bus.o_wb_adr, bus.o_wb_dat}), 128'(0));
    drv[0] = '0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    fork
      run(0, 1, 2, 0);
      run(1, 1, 2, 0);
      begin
        @(negedge i_clk); check("post_reset_idle", 128'(bus.o_grant), 128'(0));
        @(negedge i_clk); check("post_reset_m0_wins", 128'(bus.o_grant), 128'(2'b01));
      end
    join
    repeat (3) @(posedge i_clk);
    check("m0_drained", 128'(exp_q[0].size()), 128'(0));
    check("m1_drained", 128'(exp_q[1].size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
